// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the serial adder result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

  // Capture FSM: waiting for a frame start, or assembling result bits.
  typedef enum logic {
    IDLE = 1'b0,
    CAP  = 1'b1
  } cap_state_e;

  localparam int RES_W_DEF = 3;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/serial_result_collector_if.sv
// Serial-in / parallel-out bundle between serial adder, collector and consumer.
// Latency: n/a (wires only).
// Backpressure: res_valid/res_ready on the parallel side; serial side cannot stall.
interface serial_result_collector_if
  import serial_adder_pkg::*;
#(
  parameter int RES_W = RES_W_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  logic                     ser_en;
  logic                     ser_dat;
  logic [RES_W-1:0]         res_data;
  logic                     res_valid;
  logic                     res_ready;
  logic                     ovf;
  logic                     frm_err;
  logic [$clog2(DEPTH):0]   level;

  // Environment side: drives the serial stream and consumes results.
  modport master (
    output ser_en, ser_dat, res_ready,
    input  res_data, res_valid, ovf, frm_err, level
  );

  // Collector side.
  modport slave (
    input  ser_en, ser_dat, res_ready,
    output res_data, res_valid, ovf, frm_err, level
  );
endinterface

// File: rtl/result_fifo.sv
// Circular result FIFO, DEPTH words of RES_W bits, head word read from registers.
// Latency: a pushed word is at the head one cycle after the push edge (when empty).
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int RES_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [RES_W-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [RES_W-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [RES_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_pop, do_push;

  // A pop on an empty FIFO is ignored; a full FIFO only accepts when draining.
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != LW'(DEPTH)) || do_pop);

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
endmodule

// File: rtl/serial_result_collector.sv
// Deserialises MSB-first serial adder results into a FIFO of parallel words.
// Latency: word visible on res_valid the cycle after the edge capturing its LSB.
// Backpressure: res_ready gates pops; a completed word arriving on a full FIFO is dropped and flagged in ovf.
module serial_result_collector
  import serial_adder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_result_collector_if.slave  bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(RES_W + 1);

  cap_state_e        state_q;
  logic [BW-1:0]     bcnt_q;
  logic [RES_W-2:0]  shift_q;
  logic              ovf_q, ovf_d;
  logic              frm_err_q;

  logic              push, pop, full, empty;
  logic [RES_W-1:0]  push_dat, head_dat;
  logic [LW-1:0]     lvl;

  // The final CAP cycle completes the word, unless a new frame start pre-empts it.
  assign push     = (state_q == CAP) && !bus.ser_en && (bcnt_q == BW'(1));
  assign push_dat = {shift_q, bus.ser_dat};
  assign pop      = !empty && bus.res_ready;
  assign ovf_d    = ovf_q | (push && full && !pop);

  // Capture FSM with sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      shift_q   <= '0;
      ovf_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (bus.ser_en) begin
        // Frame start; in CAP the partial word is abandoned and flagged.
        if (state_q == CAP) frm_err_q <= 1'b1;
        state_q <= CAP;
        shift_q <= (RES_W-1)'(bus.ser_dat);
        bcnt_q  <= BW'(RES_W - 1);
      end else if (state_q == CAP) begin
        shift_q <= (RES_W-1)'({shift_q, bus.ser_dat});
        bcnt_q  <= bcnt_q - 1'b1;
        if (bcnt_q == BW'(1)) state_q <= IDLE;
      end
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .RES_W (RES_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .pop_dat_o  (head_dat),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (lvl)
  );

  assign bus.res_data  = head_dat;
  assign bus.res_valid = !empty;
  assign bus.level     = lvl;
  assign bus.ovf       = ovf_q;
  assign bus.frm_err   = frm_err_q;
endmodule

// File: doc/serial_result_collector.md
SERIAL_RESULT_COLLECTOR -- requirements
Module: serial_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in result words (power of two, 2..16).
REQ-002 SHALL have parameter RES_W, default 3, result width in bits (serial adder sum width).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ser_en  input  1  frame-start strobe from serial adder en_o; high for exactly one cycle per result.
REQ-006 SHALL have port ser_dat  input  1  serial result bit from adder out; MSB-first, MSB valid in the ser_en cycle.
REQ-007 SHALL have port res_data  output  RES_W  FIFO head word, parallel result.
REQ-008 SHALL have port res_valid  output  1  FIFO non-empty; res_data valid.
REQ-009 SHALL have port res_ready  input  1  consumer accepts head word when res_valid && res_ready.
REQ-010 SHALL have port ovf  output  1  sticky: a completed word was dropped because the FIFO was full.
REQ-011 SHALL have port frm_err  output  1  sticky: ser_en arrived while a frame was still being assembled.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL implement FSM states IDLE, CAP (collecting bits RES_W-2..0); bit counter bcnt counts remaining bits.
REQ-014 SHALL, in IDLE with ser_en=1, load shift register with ser_dat as MSB, set bcnt=RES_W-1, go to CAP.
REQ-015 SHALL, in CAP with ser_en=0, shift ser_dat in at LSB end and decrement bcnt each cycle.
REQ-016 SHALL, on the CAP cycle with bcnt=1, push {shift register, ser_dat} into the FIFO and return to IDLE; ser_dat ignored in IDLE when ser_en=0.
REQ-017 SHALL, in CAP with ser_en=1, discard the partial word, set frm_err, restart capture per REQ-014 (stay in CAP).
REQ-018 SHALL make a pushed word visible with res_valid=1 on the cycle after the edge capturing its LSB (latency RES_W cycles from ser_en edge).
REQ-019 SHALL drive res_valid=(level!=0) and res_data=head word directly from registers; no combinational path from res_ready to res_valid or res_data.
REQ-020 SHALL pop on res_valid && res_ready; res_ready while empty has no effect.
REQ-021 SHALL, on push with FIFO full and no pop that cycle, drop the new word, keep contents, set ovf.
REQ-022 SHALL, on simultaneous push and pop while full, accept both; level unchanged.
REQ-023 SHALL, on simultaneous push and pop while empty, complete the push only; pop ignored since res_valid=0.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; preserve order across wrap.
REQ-025 SHALL keep ovf and frm_err set until reset.

Reset
REQ-026 SHALL, on rst high, asynchronously force FSM=IDLE, bcnt=0, shift register=0, pointers=0, level=0, res_valid=0, res_data=0, ovf=0, frm_err=0.
REQ-027 SHALL discard any partial frame on reset mid-capture; a ser_en in the first cycle after rst release starts a new frame normally.

Structure
REQ-028 SHALL place FSM state enum, RES_W default and DEPTH default in shared package serial_adder_pkg.
REQ-029 SHALL implement FIFO storage/pointers as sub-module result_fifo (DEPTH, RES_W parameters; push/pop/full/empty/level); capture FSM in top.

Verification
REQ-030 Single frame: adder inputs a=2'b11, b=2'b01 -> ser_en with bits 1,0,0 -> res_valid high 3 cycles after ser_en edge, res_data=3'b100, level=1.
REQ-031 Backpressure/overflow: res_ready=0, 5 frames with sums 1,2,3,4,5 -> level=4, ovf=1, then pop sequence 1,2,3,4.
REQ-032 Full push+pop: FIFO full, res_ready=1 on cycle of 5th push -> level stays 4, ovf=0, order 2,3,4,5 after drain.
REQ-033 Frame error: ser_en, bit 1, then ser_en again one cycle later with bits 0,1,1 -> frm_err=1, only 3'b011 pushed.
REQ-034 Reset mid-frame: rst pulsed after MSB captured -> all outputs 0, no word pushed; next frame 3'b110 captured correctly.
REQ-035 Wrap: 10 frames sums 0..7,0,1 with res_ready=1 -> outputs in order, never ovf, level returns to 0.
